// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-U controller: opcodes, microstep encoding and
// control-word bit positions.
package sap_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned STEP_W   = 3;

    // Opcodes
    localparam logic [OPCODE_W-1:0] OpNop = 4'h0;
    localparam logic [OPCODE_W-1:0] OpLda = 4'h1;
    localparam logic [OPCODE_W-1:0] OpAdd = 4'h2;
    localparam logic [OPCODE_W-1:0] OpSub = 4'h3;
    localparam logic [OPCODE_W-1:0] OpSta = 4'h4;
    localparam logic [OPCODE_W-1:0] OpLdi = 4'h5;
    localparam logic [OPCODE_W-1:0] OpJmp = 4'h6;
    localparam logic [OPCODE_W-1:0] OpOut = 4'hE;
    localparam logic [OPCODE_W-1:0] OpHlt = 4'hF;

    // Microstep encoding doubles as the debug tstate value
    typedef enum logic [STEP_W-1:0] {
        StT0   = 3'd0,
        StT1   = 3'd1,
        StT2   = 3'd2,
        StT3   = 3'd3,
        StT4   = 3'd4,
        StHalt = 3'd5
    } step_e;

    // Control-word bit indices
    localparam int unsigned CwPcEnable    = 0;
    localparam int unsigned CwPcInc       = 1;
    localparam int unsigned CwPcLoad      = 2;
    localparam int unsigned CwMarLoad     = 3;
    localparam int unsigned CwRamEnable   = 4;
    localparam int unsigned CwRamLoad     = 5;
    localparam int unsigned CwIrLoad      = 6;
    localparam int unsigned CwIrEnable    = 7;
    localparam int unsigned CwRegALoad    = 8;
    localparam int unsigned CwRegAEnable  = 9;
    localparam int unsigned CwRegBLoad    = 10;
    localparam int unsigned CwRegBEnable  = 11;
    localparam int unsigned CwAluEnable   = 12;
    localparam int unsigned CwAluSubtract = 13;
    localparam int unsigned CwOutLoad     = 14;
    localparam int unsigned CwWidth       = 15;

    typedef logic [CwWidth-1:0] ctrl_word_t;

endpackage

// File: rtl/sap_microcode.sv
// Combinational microcode ROM: (microstep, opcode) -> control word plus sequencing flags.
module sap_microcode
    import sap_pkg::*;
(
    input  step_e                 state_i,
    input  logic [OPCODE_W-1:0]   opcode_i,
    output ctrl_word_t            cw_o,
    output logic                  last_step_o,
    output logic                  to_halt_o
);

    // Decode the control word for the current microstep
    always_comb begin
        cw_o        = '0;
        last_step_o = 1'b0;
        to_halt_o   = 1'b0;
        unique case (state_i)
            StT0: begin
                cw_o[CwPcEnable] = 1'b1;
                cw_o[CwMarLoad]  = 1'b1;
            end
            StT1: begin
                cw_o[CwRamEnable] = 1'b1;
                cw_o[CwIrLoad]    = 1'b1;
                cw_o[CwPcInc]     = 1'b1;
            end
            StT2: begin
                case (opcode_i)
                    OpLda, OpAdd, OpSub, OpSta: begin
                        cw_o[CwIrEnable] = 1'b1;
                        cw_o[CwMarLoad]  = 1'b1;
                    end
                    OpLdi: begin
                        cw_o[CwIrEnable] = 1'b1;
                        cw_o[CwRegALoad] = 1'b1;
                        last_step_o      = 1'b1;
                    end
                    OpJmp: begin
                        cw_o[CwIrEnable] = 1'b1;
                        cw_o[CwPcLoad]   = 1'b1;
                        last_step_o      = 1'b1;
                    end
                    OpOut: begin
                        cw_o[CwRegAEnable] = 1'b1;
                        cw_o[CwOutLoad]    = 1'b1;
                        last_step_o        = 1'b1;
                    end
                    OpHlt:   to_halt_o   = 1'b1;
                    default: last_step_o = 1'b1;  // NOP and undecoded opcodes
                endcase
            end
            StT3: begin
                case (opcode_i)
                    OpLda: begin
                        cw_o[CwRamEnable] = 1'b1;
                        cw_o[CwRegALoad]  = 1'b1;
                        last_step_o       = 1'b1;
                    end
                    OpAdd, OpSub: begin
                        cw_o[CwRamEnable] = 1'b1;
                        cw_o[CwRegBLoad]  = 1'b1;
                    end
                    OpSta: begin
                        cw_o[CwRegAEnable] = 1'b1;
                        cw_o[CwRamLoad]    = 1'b1;
                        last_step_o        = 1'b1;
                    end
                    // Only reachable if the opcode changed after T2; recover to fetch
                    default: last_step_o = 1'b1;
                endcase
            end
            StT4: begin
                case (opcode_i)
                    OpAdd, OpSub: begin
                        cw_o[CwAluEnable]   = 1'b1;
                        cw_o[CwRegALoad]    = 1'b1;
                        cw_o[CwAluSubtract] = (opcode_i == OpSub);
                        last_step_o         = 1'b1;
                    end
                    default: last_step_o = 1'b1;
                endcase
            end
            StHalt: begin
                cw_o = '0;
            end
            default: last_step_o = 1'b1;  // illegal encodings fall back to fetch
        endcase
    end

endmodule

// File: rtl/sap_controller.sv
// SAP-U control sequencer: microstep register, free-run/single-step gating and
// strobe outputs.
module sap_controller
    import sap_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                step_mode,
    input  logic                step,
    output logic                pc_enable,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_load,
    output logic                ram_enable,
    output logic                ram_load,
    output logic                ir_load,
    output logic                ir_enable,
    output logic                reg_a_load,
    output logic                reg_a_enable,
    output logic                reg_b_load,
    output logic                reg_b_enable,
    output logic                alu_enable,
    output logic                alu_subtract,
    output logic                out_load,
    output logic                halted,
    output logic [STEP_W-1:0]   tstate
);

    step_e      state_q, state_d;
    ctrl_word_t cw_raw;
    ctrl_word_t cw;
    logic       last_step;
    logic       to_halt;
    logic       advance;

    sap_microcode u_microcode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .cw_o        (cw_raw),
        .last_step_o (last_step),
        .to_halt_o   (to_halt)
    );

    assign advance = step_mode ? step : 1'b1;

    // Next microstep: hold unless advancing; HALT is sticky until reset
    always_comb begin
        state_d = state_q;
        if (state_q == StHalt) begin
            state_d = StHalt;
        end else if (advance) begin
            if (to_halt) begin
                state_d = StHalt;
            end else if (last_step) begin
                state_d = StT0;
            end else begin
                unique case (state_q)
                    StT0:    state_d = StT1;
                    StT1:    state_d = StT2;
                    StT2:    state_d = StT3;
                    StT3:    state_d = StT4;
                    default: state_d = StT0;
                endcase
            end
        end
    end

    // Microstep register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StT0;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes fire only on advancing cycles; reset masks them without waiting for a clock
    always_comb begin
        cw = '0;
        if (advance && reset) begin
            cw = cw_raw;
        end
    end

    assign pc_enable    = cw[CwPcEnable];
    assign pc_inc       = cw[CwPcInc];
    assign pc_load      = cw[CwPcLoad];
    assign mar_load     = cw[CwMarLoad];
    assign ram_enable   = cw[CwRamEnable];
    assign ram_load     = cw[CwRamLoad];
    assign ir_load      = cw[CwIrLoad];
    assign ir_enable    = cw[CwIrEnable];
    assign reg_a_load   = cw[CwRegALoad];
    assign reg_a_enable = cw[CwRegAEnable];
    assign reg_b_load   = cw[CwRegBLoad];
    assign reg_b_enable = cw[CwRegBEnable];
    assign alu_enable   = cw[CwAluEnable];
    assign alu_subtract = cw[CwAluSubtract];
    assign out_load     = cw[CwOutLoad];

    assign halted = (state_q == StHalt);
    assign tstate = state_q;

endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller with a queue-based scoreboard.
module tb_sap_controller;

    // Strobe masks in the order of cw_obs below
    localparam logic [14:0] PCE  = 15'h4000;
    localparam logic [14:0] PCI  = 15'h2000;
    localparam logic [14:0] PCL  = 15'h1000;
    localparam logic [14:0] MARL = 15'h0800;
    localparam logic [14:0] RAME = 15'h0400;
    localparam logic [14:0] RAML = 15'h0200;
    localparam logic [14:0] IRL  = 15'h0100;
    localparam logic [14:0] IRE  = 15'h0080;
    localparam logic [14:0] AL   = 15'h0040;
    localparam logic [14:0] AE   = 15'h0020;
    localparam logic [14:0] BL   = 15'h0010;
    localparam logic [14:0] BE   = 15'h0008;
    localparam logic [14:0] ALUE = 15'h0004;
    localparam logic [14:0] SUBT = 15'h0002;
    localparam logic [14:0] OUTL = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;
    localparam logic [14:0] BUSMASK = PCE | RAME | IRE | AE | BE | ALUE;

    typedef struct packed {
        logic [2:0]  t;
        logic [14:0] cw;
        logic        h;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic        pc_enable, pc_inc, pc_load, mar_load, ram_enable, ram_load, ir_load, ir_enable;
    logic        reg_a_load, reg_a_enable, reg_b_load, reg_b_enable;
    logic        alu_enable, alu_subtract, out_load, halted;
    logic [2:0]  tstate;
    logic [14:0] cw_obs;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          pinc_cnt = 0;
    string       tag = "init";

    sap_controller dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .step_mode    (step_mode),
        .step         (step),
        .pc_enable    (pc_enable),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .mar_load     (mar_load),
        .ram_enable   (ram_enable),
        .ram_load     (ram_load),
        .ir_load      (ir_load),
        .ir_enable    (ir_enable),
        .reg_a_load   (reg_a_load),
        .reg_a_enable (reg_a_enable),
        .reg_b_load   (reg_b_load),
        .reg_b_enable (reg_b_enable),
        .alu_enable   (alu_enable),
        .alu_subtract (alu_subtract),
        .out_load     (out_load),
        .halted       (halted),
        .tstate       (tstate)
    );

    assign cw_obs = {pc_enable, pc_inc, pc_load, mar_load, ram_enable, ram_load, ir_load,
                     ir_enable, reg_a_load, reg_a_enable, reg_b_load, reg_b_enable,
                     alu_enable, alu_subtract, out_load};

    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with what the DUT shows now
    task automatic check();
        exp_t e;
        logic one_bus;
        e = sb.pop_front();
        one_bus = ($countones(cw_obs & BUSMASK) <= 1);
        pinc_cnt += int'(pc_inc);
        total += 4;
        assert (tstate === e.t) else begin
            bad++;
            $error("FAIL %s tstate: got %0d want %0d", tag, tstate, e.t);
        end
        assert (cw_obs === e.cw) else begin
            bad++;
            $error("FAIL %s strobes: got %h want %h", tag, cw_obs, e.cw);
        end
        assert (halted === e.h) else begin
            bad++;
            $error("FAIL %s halted: got %b want %b", tag, halted, e.h);
        end
        assert (one_bus === 1'b1) else begin
            bad++;
            $error("FAIL %s bus drivers: got %h want at most one", tag, cw_obs & BUSMASK);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check before the rising edge
    task automatic cyc(input logic rs, input logic [3:0] op, input logic sm, input logic st,
                       input logic [2:0] t, input logic [14:0] cw, input logic h);
        @(negedge clk);
        reset = rs;
        opcode = op;
        step_mode = sm;
        step = st;
        sb.push_back('{t: t, cw: cw, h: h});
        #1;
        check();
    endtask

    // Free-run fetch; the opcode shown during fetch is junk and must not matter
    task automatic fetch(input logic [3:0] junk);
        cyc(1'b1, junk, 1'b0, 1'b0, 3'd0, PCE | MARL, 1'b0);
        cyc(1'b1, ~junk, 1'b0, 1'b0, 3'd1, RAME | IRL | PCI, 1'b0);
    endtask

    task automatic count_check(input int want);
        total++;
        assert (pinc_cnt === want) else begin
            bad++;
            $error("FAIL %s pc_inc count: got %0d want %0d", tag, pinc_cnt, want);
        end
    endtask

    initial begin
        #1 reset = 1'b0;

        tag = "reset";
        cyc(1'b0, 4'h5, 1'b0, 1'b0, 3'd0, NONE, 1'b0);
        cyc(1'b0, 4'h5, 1'b0, 1'b1, 3'd0, NONE, 1'b0);

        tag = "ldi_out";
        pinc_cnt = 0;
        fetch(4'h3);
        cyc(1'b1, 4'h5, 1'b0, 1'b0, 3'd2, IRE | AL, 1'b0);
        fetch(4'h1);
        cyc(1'b1, 4'hE, 1'b0, 1'b0, 3'd2, AE | OUTL, 1'b0);
        count_check(2);

        tag = "add";
        fetch(4'h6);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 3'd2, IRE | MARL, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 3'd3, RAME | BL, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 3'd4, ALUE | AL, 1'b0);

        tag = "sub";
        fetch(4'h2);
        cyc(1'b1, 4'h3, 1'b0, 1'b0, 3'd2, IRE | MARL, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0, 3'd3, RAME | BL, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0, 3'd4, ALUE | AL | SUBT, 1'b0);

        tag = "lda";
        fetch(4'hF);
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 3'd2, IRE | MARL, 1'b0);
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 3'd3, RAME | AL, 1'b0);

        tag = "sta";
        fetch(4'h0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0, 3'd2, IRE | MARL, 1'b0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0, 3'd3, AE | RAML, 1'b0);

        tag = "jmp";
        fetch(4'h4);
        cyc(1'b1, 4'h6, 1'b0, 1'b0, 3'd2, IRE | PCL, 1'b0);

        tag = "nop";
        fetch(4'h2);
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 3'd2, NONE, 1'b0);

        tag = "undef";
        fetch(4'h5);
        cyc(1'b1, 4'hA, 1'b0, 1'b0, 3'd2, NONE, 1'b0);

        // Single-step LDI with three idle cycles between pulses
        tag = "single_step";
        pinc_cnt = 0;
        cyc(1'b1, 4'h5, 1'b1, 1'b1, 3'd0, PCE | MARL, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'h5, 1'b1, 1'b0, 3'd1, NONE, 1'b0);
        cyc(1'b1, 4'h5, 1'b1, 1'b1, 3'd1, RAME | IRL | PCI, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'h5, 1'b1, 1'b0, 3'd2, NONE, 1'b0);
        cyc(1'b1, 4'h5, 1'b1, 1'b1, 3'd2, IRE | AL, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'h5, 1'b1, 1'b0, 3'd0, NONE, 1'b0);
        count_check(1);

        // Leave single-step mid-instruction; microstep carries over
        tag = "mode_switch";
        cyc(1'b1, 4'hA, 1'b1, 1'b1, 3'd0, PCE | MARL, 1'b0);
        cyc(1'b1, 4'hA, 1'b0, 1'b0, 3'd1, RAME | IRL | PCI, 1'b0);
        cyc(1'b1, 4'hA, 1'b0, 1'b0, 3'd2, NONE, 1'b0);

        tag = "hlt";
        fetch(4'h1);
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 3'd2, NONE, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'hF, 1'b0, 1'b1, 3'd5, NONE, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'hF, 1'b1, 1'b1, 3'd5, NONE, 1'b1);

        // Reset mid-cycle clears HALT without a clock edge
        tag = "hlt_reset";
        @(negedge clk);
        #2 reset = 1'b0;
        sb.push_back('{t: 3'd0, cw: NONE, h: 1'b0});
        #1 check();
        cyc(1'b0, 4'h1, 1'b0, 1'b0, 3'd0, NONE, 1'b0);

        tag = "lda_abort";
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 3'd0, PCE | MARL, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 3'd1, RAME | IRL | PCI, 1'b0);
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 3'd2, IRE | MARL, 1'b0);
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 3'd3, RAME | AL, 1'b0);
        #1 reset = 1'b0;
        sb.push_back('{t: 3'd0, cw: NONE, h: 1'b0});
        #1 check();
        cyc(1'b0, 4'h1, 1'b0, 1'b0, 3'd0, NONE, 1'b0);

        tag = "restart";
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 3'd0, PCE | MARL, 1'b0);
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 3'd1, RAME | IRL | PCI, 1'b0);
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 3'd2, IRE | MARL, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap_controller.md
# sap_controller

Microcoded sequencer for the SAP-U datapath. Steps a fetch/execute microstep counter, decodes the instruction register opcode, and drives the load/enable strobes for registers A and B, the ALU, PC, MAR, RAM, IR and the output register. Sits at the top level beside the datapath and replaces the externally driven control inputs. Supports free-run and single-step operation.

## Interface
- OPCODE_W, 4, opcode field width; upper nibble of IR.
- STEP_W, 3, microstep counter width; covers T0..T4 plus HALT.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears the controller immediately.
- opcode  in  OPCODE_W  current IR opcode; held stable by the IR from T2 onward.
- step_mode  in  1  1 = single-step; 0 = free-run.
- step  in  1  advance request; sampled every cycle in single-step mode.
- pc_enable, pc_inc, pc_load  out  1 each  PC drives bus / increment / load from bus.
- mar_load, ram_enable, ram_load, ir_load, ir_enable  out  1 each  memory and IR strobes; ir_enable drives the IR operand nibble.
- reg_a_load, reg_a_enable, reg_b_load, reg_b_enable  out  1 each  register A/B strobes.
- alu_enable, alu_subtract  out  1 each  ALU drives bus; subtract selects A−B.
- out_load  out  1  output register load.
- halted  out  1  controller is in HALT.
- tstate  out  STEP_W  current microstep, for debug and bench visibility.

## Operation
- Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, E OUT, F HLT. Undecoded opcodes execute as NOP.
- Fetch, common to all opcodes:
  - T0: pc_enable, mar_load.
  - T1: ram_enable, ir_load, pc_inc.
- Execute steps:
  - LDA: T2 ir_enable+mar_load; T3 ram_enable+reg_a_load; last step.
  - ADD: T2 ir_enable+mar_load; T3 ram_enable+reg_b_load; T4 alu_enable+reg_a_load; last step.
  - SUB: same as ADD, with alu_subtract asserted at T4.
  - STA: T2 ir_enable+mar_load; T3 reg_a_enable+ram_load; last step.
  - LDI: T2 ir_enable+reg_a_load; last step.
  - JMP: T2 ir_enable+pc_load; last step.
  - OUT: T2 reg_a_enable+out_load; last step.
  - NOP/undefined: T2 with no strobes; last step.
  - HLT: T2 with no strobes; next state is HALT.
- After an advance on a last step, the next state is T0; no idle microsteps.
- The control word is registered state decoded combinationally and ANDed with `advance`. advance = 1 in free-run mode; advance = step in single-step mode. State changes only when advance = 1. No strobe is ever active on a non-advancing cycle, so pc_inc and loads fire exactly once per microstep.
- At most one bus driver (pc_enable, ram_enable, ir_enable, reg_a_enable, reg_b_enable, alu_enable) is active in any cycle.
- HALT: all strobes 0, halted = 1, tstate = 5. Only reset exits HALT; step is ignored.
- Changing step_mode mid-instruction takes effect on the next cycle. The microstep is preserved.

## Timing
- While reset = 0: state T0, all strobes 0, halted 0, tstate 0.
- First cycle after reset release in free-run: T0 word (pc_enable, mar_load) is active.
- Instruction length in cycles in free-run: LDI/JMP/OUT/NOP = 3; LDA/STA = 4; ADD/SUB = 5; HLT = 3, then HALT.
- opcode is sampled combinationally at T2–T4. An opcode change during T0/T1 has no effect.
- Reset asserted mid-instruction aborts it at once. The outputs are forced to reset values asynchronously, without waiting for a clock edge.

## Structure
- Shared package sap_pkg holds:
  - opcode localparams;
  - microstep/state encoding (T0..T4 = 0..4, HALT = 5);
  - control-word bit indices.
- Sub-module sap_microcode: purely combinational decode (state, opcode) → {control word, last_step, to_halt}.
- sap_controller holds the state register, the advance gating, and the output AND.

## Test plan
- Free-run LDI (0x5) then OUT (0xE) → T0,T1,T2 then T0,T1,T2. reg_a_load at cycle 2, out_load at cycle 5. pc_inc exactly twice.
- ADD (0x2) → reg_b_load at T3; alu_enable+reg_a_load at T4, alu_subtract=0. SUB (0x3) is identical except alu_subtract=1 at T4. Next cycle is T0.
- HLT (0xF) → HALT after T2, halted=1, all strobes 0. 10 cycles of step=1 produce no change. reset low returns the controller to T0.
- Single-step: step_mode=1, step pulses with gaps of 3 idle cycles → strobes appear only on pulse cycles. tstate advances one per pulse. pc_inc is high for exactly 1 cycle per fetch.
- Opcode 0xA (undefined) → 3-cycle NOP, no strobes at T2.
- Reset asserted mid-T3 of LDA → all outputs 0 asynchronously. After release, the controller restarts at T0 with no reg_a_load.
